// File: rtl/fpnew_classifier_pipe.sv
// ---------------------------------------------------------------------------
// fpnew_classifier_pipe
//
// Classifies NumOperands floating-point operands per transaction. Each operand
// has its own format select. Narrow formats are checked for NaN-boxing. Each
// operand produces an 8-bit fp_info word and a 10-bit RISC-V FCLASS one-hot
// mask. The results then pass through a stallable valid/ready pipeline of
// NumPipeRegs stages. An opaque tag travels with each transaction.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   flush_i      synchronous kill of every in-flight transaction
//   in_valid_i   input transaction valid
//   in_ready_o   input accepted when in_valid_i & in_ready_o
//   operands_i   operand op at [op*WIDTH +: WIDTH]
//   fmt_i        per-operand format: 0 FP32, 1 FP64, 2 FP16, 3 FP8 E5M2, 4 BF16
//   tag_i        opaque tag, returned unchanged
//   out_valid_o  result valid
//   out_ready_i  downstream ready
//   info_o       per op: normal,subnormal,zero,inf,nan,snan,qnan,boxed (MSB..LSB)
//   class_o      per-op FCLASS one-hot mask
//   tag_o        tag of the presented result
//   busy_o       any pipeline stage holds a valid entry
// ---------------------------------------------------------------------------
module fpnew_classifier_pipe #(
    parameter int WIDTH       = 64,
    parameter int NumOperands = 3,
    parameter int NumPipeRegs = 1,
    parameter int TagWidth    = 4,
    parameter bit NanBoxCheck = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NumOperands*WIDTH-1:0]   operands_i,
    input  logic [NumOperands*3-1:0]       fmt_i,
    input  logic [TagWidth-1:0]            tag_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NumOperands*8-1:0]       info_o,
    output logic [NumOperands*10-1:0]      class_o,
    output logic [TagWidth-1:0]            tag_o,
    output logic                           busy_o
);

    // Operands are widened to at least 64 bits. This keeps field extraction
    // for every format in range, even when WIDTH is narrower than FP64.
    localparam int EXT_W   = (WIDTH > 64) ? WIDTH : 64;
    localparam int INFO_W  = NumOperands * 8;
    localparam int CLASS_W = NumOperands * 10;
    localparam int NS      = (NumPipeRegs == 0) ? 1 : NumPipeRegs;

    localparam logic [EXT_W-1:0] EXT_ONE  = EXT_W'(1);
    localparam logic [EXT_W-1:0] EXT_ONES = {EXT_W{1'b1}};

    // Returns {class[9:0], info[7:0]} for one operand.
    function automatic logic [17:0] classify(input logic [EXT_W-1:0] op,
                                             input logic [2:0]       fmt);
        int               fw;
        int               ew;
        int               mw;
        logic             fmt_ok;
        logic             upper_ok;
        logic             boxed;
        logic             sign;
        logic             man_msb;
        logic [10:0]      exp_v;
        logic [10:0]      exp_max;
        logic [51:0]      man_v;
        logic [51:0]      man_mask;
        logic [EXT_W-1:0] upper_mask;
        logic             exp_zero;
        logic             exp_ones;
        logic             man_zero;
        logic             is_norm;
        logic             is_sub;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
        logic             is_snan;
        logic             is_qnan;

        fmt_ok = 1'b1;
        case (fmt)
            3'd0:    begin fw = 32; ew = 8;  mw = 23; end
            3'd1:    begin fw = 64; ew = 11; mw = 52; end
            3'd2:    begin fw = 16; ew = 5;  mw = 10; end
            3'd3:    begin fw = 8;  ew = 5;  mw = 2;  end
            3'd4:    begin fw = 16; ew = 8;  mw = 7;  end
            default: begin fw = 8;  ew = 5;  mw = 2;  fmt_ok = 1'b0; end
        endcase
        if (fw > WIDTH) begin
            fmt_ok = 1'b0;
        end

        exp_max  = 11'((32'd1 << ew) - 32'd1);
        man_mask = (52'd1 << mw) - 52'd1;
        exp_v    = 11'(op >> mw) & exp_max;
        man_v    = 52'(op) & man_mask;
        sign     = |(op & (EXT_ONE << (fw - 1)));
        man_msb  = |(op & (EXT_ONE << (mw - 1)));

        // Bits between the format width and WIDTH must all be 1 for a valid box.
        upper_mask = (EXT_ONES << fw) & ~(EXT_ONES << WIDTH);
        upper_ok   = &(op | ~upper_mask);

        boxed = fmt_ok & ((fw == WIDTH) | !NanBoxCheck | upper_ok);

        exp_zero = (exp_v == 11'd0);
        exp_ones = (exp_v == exp_max);
        man_zero = (man_v == 52'd0);

        is_norm = boxed & !exp_zero & !exp_ones;
        is_zero = boxed & exp_zero & man_zero;
        is_sub  = boxed & exp_zero & !man_zero;
        is_inf  = boxed & exp_ones & man_zero;
        // An unboxed operand reads as the canonical quiet NaN.
        is_nan  = !boxed | (exp_ones & !man_zero);
        is_snan = boxed & is_nan & !man_msb;
        is_qnan = is_nan & !is_snan;

        return {is_qnan, is_snan,
                !sign & is_inf, !sign & is_norm, !sign & is_sub, !sign & is_zero,
                sign & is_zero, sign & is_sub, sign & is_norm, sign & is_inf,
                is_norm, is_sub, is_zero, is_inf, is_nan, is_snan, is_qnan, boxed};
    endfunction

    logic [INFO_W-1:0]  w_info;
    logic [CLASS_W-1:0] w_class;

    genvar gi;
    generate
        for (gi = 0; gi < NumOperands; gi++) begin : g_op
            logic [EXT_W-1:0] w_ext;
            logic [17:0]      w_res;
            assign w_ext                = EXT_W'(operands_i[gi*WIDTH +: WIDTH]);
            assign w_res                = classify(w_ext, fmt_i[gi*3 +: 3]);
            assign w_info[gi*8 +: 8]    = w_res[7:0];
            assign w_class[gi*10 +: 10] = w_res[17:8];
        end

        if (NumPipeRegs == 0) begin : g_comb
            assign out_valid_o = in_valid_i;
            assign in_ready_o  = out_ready_i;
            assign info_o      = w_info;
            assign class_o     = w_class;
            assign tag_o       = tag_i;
            assign busy_o      = 1'b0;
        end else begin : g_pipe
            logic [NS-1:0]       w_stg_valid;
            logic [INFO_W-1:0]   w_stg_info  [NS];
            logic [CLASS_W-1:0]  w_stg_class [NS];
            logic [TagWidth-1:0] w_stg_tag   [NS];
            logic [NS-1:0]       w_load;

            // Ready ripples back from the output: a stage may load when it is
            // empty or when the stage after it is loading in the same cycle.
            always_comb begin : p_ready
                logic v_rdy;
                v_rdy  = out_ready_i;
                w_load = '0;
                for (int k = NS - 1; k >= 0; k--) begin
                    w_load[k] = !w_stg_valid[k] | v_rdy;
                    v_rdy     = w_load[k];
                end
            end

            for (gi = 0; gi < NS; gi++) begin : g_stage
                logic                r_valid;
                logic [INFO_W-1:0]   r_info;
                logic [CLASS_W-1:0]  r_class;
                logic [TagWidth-1:0] r_tag;
                logic                w_up_valid;
                logic [INFO_W-1:0]   w_up_info;
                logic [CLASS_W-1:0]  w_up_class;
                logic [TagWidth-1:0] w_up_tag;

                if (gi == 0) begin : g_src
                    assign w_up_valid = in_valid_i;
                    assign w_up_info  = w_info;
                    assign w_up_class = w_class;
                    assign w_up_tag   = tag_i;
                end else begin : g_src
                    assign w_up_valid = w_stg_valid[gi-1];
                    assign w_up_info  = w_stg_info[gi-1];
                    assign w_up_class = w_stg_class[gi-1];
                    assign w_up_tag   = w_stg_tag[gi-1];
                end

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_valid <= 1'b0;
                        r_info  <= '0;
                        r_class <= '0;
                        r_tag   <= '0;
                    end else begin
                        // Flush also drops whatever is presented at the input.
                        if (flush_i) begin
                            r_valid <= 1'b0;
                        end else if (w_load[gi]) begin
                            r_valid <= w_up_valid;
                        end
                        if (w_load[gi]) begin
                            r_info  <= w_up_info;
                            r_class <= w_up_class;
                            r_tag   <= w_up_tag;
                        end
                    end
                end

                assign w_stg_valid[gi] = r_valid;
                assign w_stg_info[gi]  = r_info;
                assign w_stg_class[gi] = r_class;
                assign w_stg_tag[gi]   = r_tag;
            end

            assign in_ready_o  = w_load[0];
            assign out_valid_o = w_stg_valid[NS-1];
            assign info_o      = w_stg_info[NS-1];
            assign class_o     = w_stg_class[NS-1];
            assign tag_o       = w_stg_tag[NS-1];
            assign busy_o      = |w_stg_valid;
        end
    endgenerate

endmodule
